// File: rtl/sa_pkg.sv
// Shared definitions for the row SRAM streamer.
// Holds the FSM state encoding, the stream FIFO depth, the read credit
// limit and the helper that decides whether another read may be issued.
package sa_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int STREAM_FIFO_DEPTH = 3;
  localparam int FIFO_CNT_W        = $clog2(STREAM_FIFO_DEPTH + 1);

  // Reads in flight plus rows already buffered may never exceed the FIFO
  // depth, so a returning row always has a slot regardless of backpressure.
  localparam int CREDIT_LIMIT = STREAM_FIFO_DEPTH;

  // True when one more read fits within the credit limit.
  function automatic logic credit_ok(input logic [FIFO_CNT_W-1:0] fifo_count,
                                     input logic                  inflight);
    return (int'(fifo_count) + int'(inflight)) < CREDIT_LIMIT;
  endfunction

endpackage

// File: rtl/sync_stream_fifo.sv
// Small first-word-fall-through FIFO for the row stream.
// Ports:
//   CLK, RSTn        clock, synchronous active-low reset
//   push, push_data  write one entry
//   pop              remove the head entry (ignored when empty)
//   head             current head entry (valid when valid=1)
//   valid            registered "not empty" flag
//   count            registered occupancy
module sync_stream_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_next_s;
  logic             valid_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(DEPTH - 1)) begin
      return '0;
    end else begin
      return ptr + PTR_W'(1);
    end
  endfunction

  assign do_pop_s  = pop && (count_r != '0);
  // A full FIFO may still accept a push when the head leaves in the same cycle.
  assign do_push_s = push && ((count_r != CNT_W'(DEPTH)) || do_pop_s);

  // Next occupancy: simultaneous push and pop leave it unchanged.
  always_comb begin
    count_next_s = count_r;
    if (do_push_s && !do_pop_s) begin
      count_next_s = count_r + CNT_W'(1);
    end else if (!do_push_s && do_pop_s) begin
      count_next_s = count_r - CNT_W'(1);
    end else begin
      count_next_s = count_r;
    end
  end

  // Pointer, occupancy and valid-flag registers.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      valid_r  <= 1'b0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (do_pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      count_r <= count_next_s;
      valid_r <= (count_next_s != '0);
    end
  end

  // Storage array; contents are only meaningful behind a valid pointer,
  // so it carries no reset.
  always_ff @(posedge CLK) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign valid = valid_r;
  assign count = count_r;

endmodule

// File: rtl/sram_row_streamer.sv
// Read-side front end for the row SRAM. A START request captures a base
// row and a row count, then the block issues synchronous reads and hands
// every returned row to the operand feeder over a valid/ready stream.
// Ports:
//   CLK, RSTn                 clock, synchronous active-low reset
//   START_in, BASE_ADDR_in,   burst request (sampled only when idle)
//   LEN_in
//   SRAM_CSn/WEn/ADDR/BE      SRAM read port (writes never issued)
//   SRAM_D_in                 SRAM read data, one cycle after the read
//   DATA_out/VALID_out/       row stream towards the consumer
//   READY_in
//   BUSY_out, DONE_out        burst status
module sram_row_streamer
  import sa_pkg::*;
#(
  parameter int BWIDTH   = 256,
  parameter int AWIDTH   = 10,
  parameter int NUM_ROWS = 1024
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              START_in,
  input  logic [AWIDTH-1:0] BASE_ADDR_in,
  input  logic [AWIDTH:0]   LEN_in,
  output logic              SRAM_CSn,
  output logic              SRAM_WEn,
  output logic [AWIDTH-1:0] SRAM_ADDR,
  output logic [BWIDTH-1:0] SRAM_BE,
  input  logic [BWIDTH-1:0] SRAM_D_in,
  output logic [BWIDTH-1:0] DATA_out,
  output logic              VALID_out,
  input  logic              READY_in,
  output logic              BUSY_out,
  output logic              DONE_out
);

  localparam int LW = AWIDTH + 1;

  state_t                  state_r;
  logic [AWIDTH-1:0]       base_r;
  logic [LW-1:0]           len_r;
  logic [LW-1:0]           issued_r;
  logic                    inflight_r;
  logic                    busy_r;
  logic                    done_r;
  logic [FIFO_CNT_W-1:0]   fifo_count_s;
  logic                    issue_s;
  logic                    last_issue_s;
  logic                    pop_s;

  // Row count of the SRAM is informational only; addresses wrap at 2^AWIDTH.
  logic [31:0] unused_num_rows;
  assign unused_num_rows = NUM_ROWS;

  // A read goes out only while issuing and within credit. The term depends
  // on registers only (never on READY_in); RSTn gates it so a read cannot
  // slip out during the reset cycle.
  assign issue_s      = RSTn && (state_r == ST_ISSUE) && credit_ok(fifo_count_s, inflight_r);
  assign last_issue_s = issue_s && ((issued_r + LW'(1)) == len_r);
  assign pop_s        = VALID_out && READY_in;

  assign SRAM_CSn  = ~issue_s;
  assign SRAM_WEn  = 1'b1;
  assign SRAM_BE   = '0;
  assign SRAM_ADDR = base_r + issued_r[AWIDTH-1:0];

  // Burst sequencer with registered BUSY/DONE.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_r  <= ST_IDLE;
      base_r   <= '0;
      len_r    <= '0;
      issued_r <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (START_in) begin
            base_r   <= BASE_ADDR_in;
            len_r    <= LEN_in;
            issued_r <= '0;
            if (LEN_in == '0) begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
            end else begin
              state_r <= ST_ISSUE;
              busy_r  <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (issue_s) begin
            issued_r <= issued_r + LW'(1);
            if (last_issue_s) begin
              state_r <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // Every issued row must have been handed downstream.
          if ((fifo_count_s == '0) && !inflight_r) begin
            state_r <= ST_DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Marks the cycle in which SRAM_D_in carries the row read one cycle
  // earlier; the SRAM output merely holds otherwise.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      inflight_r <= 1'b0;
    end else begin
      inflight_r <= issue_s;
    end
  end

  sync_stream_fifo #(
    .WIDTH(BWIDTH),
    .DEPTH(STREAM_FIFO_DEPTH)
  ) u_fifo (
    .CLK      (CLK),
    .RSTn     (RSTn),
    .push     (inflight_r),
    .push_data(SRAM_D_in),
    .pop      (pop_s),
    .head     (DATA_out),
    .valid    (VALID_out),
    .count    (fifo_count_s)
  );

  assign BUSY_out = busy_r;
  assign DONE_out = done_r;

endmodule

// File: doc/sram_row_streamer.md
Name: sram_row_streamer

Overview:
- Read-side front end for the row SRAM: on START, issues a burst of synchronous row reads and hands each returned row downstream as a valid/ready stream.
- Consumer is the systolic-array operand feeder.
- Absorbs the SRAM's 1-cycle read latency and downstream backpressure without dropping or duplicating rows.
- Sole SRAM master while BUSY; writes never issued.

Parameters:
- BWIDTH, 256, bits per row (matches SRAM).
- AWIDTH, 10, row address width.
- NUM_ROWS, 1024, rows in SRAM; informational, addressing wraps at 2^AWIDTH.

Ports:
- CLK  in  1  clock; all state updates on posedge CLK.
- RSTn  in  1  reset, synchronous, active-low.
- START_in  in  1  1-cycle request; sampled only in IDLE.
- BASE_ADDR_in  in  AWIDTH  first row; captured with START_in.
- LEN_in  in  AWIDTH+1  row count, 0..2^AWIDTH; captured with START_in.
- SRAM_CSn  out  1  SRAM chip select, active-low.
- SRAM_WEn  out  1  tied 1 (read only).
- SRAM_ADDR  out  AWIDTH  row address.
- SRAM_BE  out  BWIDTH  tied 0.
- SRAM_D_in  in  BWIDTH  SRAM D_out.
- DATA_out  out  BWIDTH  row data at FIFO head.
- VALID_out  out  1  DATA_out valid.
- READY_in  in  1  consumer accepts; a beat transfers when VALID_out & READY_in.
- BUSY_out  out  1  high from the cycle after START accept until DONE.
- DONE_out  out  1  1-cycle pulse after the last beat transfers.

Behaviour:
- Reset (RSTn=0 at posedge): state=IDLE, FIFO empty, inflight=0, counters 0.
  - Outputs: SRAM_CSn=1, SRAM_ADDR=0, VALID_out=0, BUSY_out=0, DONE_out=0.
  - SRAM_CSn is also gated high combinationally while RSTn=0, so no read is issued in the reset cycle.
  - Reset mid-burst aborts it; data still in flight is discarded.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
  - IDLE: START_in=1 latches base and length. If LEN=0, go to DONE; otherwise go to ISSUE.
  - ISSUE: go to DRAIN in the cycle the last read is issued.
  - DRAIN: wait until FIFO empty and inflight=0, then go to DONE.
  - DONE: DONE_out=1 for one cycle, then go to IDLE.
  - START_in outside IDLE is ignored.
- Read issue:
  - SRAM_CSn=0 iff state=ISSUE and (fifo_count + inflight) < 3.
  - SRAM_CSn is combinational from registers only; there is no combinational path from READY_in.
  - SRAM_ADDR = base + issued_count, modulo 2^AWIDTH (wraps 2^AWIDTH-1 -> 0).
- Return path:
  - inflight is set in the cycle after a read is issued.
  - SRAM_D_in is captured into the FIFO at that cycle's closing edge.
  - SRAM output holds when not read, so capture happens only when inflight=1.
- FIFO: 3 entries, first-word-fall-through.
  - DATA_out = head entry; VALID_out = (count != 0).
  - Push and pop in the same cycle leave the count unchanged.
  - The credit rule guarantees no overflow.
- Latency and throughput:
  - START accepted at edge E0; first read issued in cycle E0+1.
  - First VALID_out in cycle E0+3.
  - With READY_in held 1: one row per cycle sustained; LEN rows complete in LEN+3 cycles from START.
- Backpressure: with READY_in=0, at most 3 rows are buffered, then SRAM_CSn stays 1. DATA_out stays stable while VALID_out=1 and no transfer occurs.
- Ordering: rows are delivered strictly in address order, exactly LEN beats.
- LEN = 2^AWIDTH reads every row once; the counter is AWIDTH+1 bits wide.

Decomposition:
- Shared package/header sa_pkg:
  - FSM state encoding (IDLE, ISSUE, DRAIN, DONE).
  - STREAM_FIFO_DEPTH=3.
  - Credit limit constant.
- Sub-module: sync_stream_fifo.
  - Parameters: WIDTH, DEPTH.
  - Interface: push/pop/count, first-word-fall-through.
  - Same CLK and synchronous RSTn.

Test Plan:
- BASE=0x010, LEN=4, READY=1, SRAM preloaded row[i]=i -> DATA 0x10..0x13 on 4 consecutive cycles. First VALID in cycle E0+3; DONE pulses once; BUSY low after.
- BASE=0x3FE, LEN=4 -> SRAM_ADDR sequence 0x3FE,0x3FF,0x000,0x001; data in that order.
- LEN=6, READY toggling 1,0,0,0,1,... -> no more than 3 reads outstanding/buffered; exactly 6 beats in order with no duplicates; DATA stable while stalled.
- LEN=0 -> DONE pulses 1 cycle after START; SRAM_CSn never low; VALID never high.
- RSTn=0 for one cycle mid-burst (after 2 of 8 beats) -> next cycle all outputs at reset values, no SRAM_CSn low during the reset cycle. A new START then streams correctly.
- START pulsed while BUSY (LEN=2 running, second START with BASE=0x100) -> ignored; only the first burst's 2 rows are delivered.
